fadd_stream_ctrl: RTL and testbench

Issue/retire controller that wraps `pipelined_fadder`. It accepts FP32 add/sub requests over a valid/ready handshake and registers the operands onto the adder inputs. It tracks each in-flight operation through the adder's fixed-latency pipeline, then captures each sum with its tag and result-class flags into an output FIFO. Credit-based issue guarantees no result is ever dropped, so the adder enable stays high and the adder never stalls.

---
 rtl/fadd_stream_ctrl_if.sv | 28 ++
 rtl/fadd_stream_ctrl.sv | 158 +++++++++++++++
 tb/tb_fadd_stream_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fadd_stream_ctrl_if.sv
// Request/result handshake bundle for fadd_stream_ctrl.
// The slave modport is the controller view; master is the producer/consumer side.
interface fadd_stream_ctrl_if #(
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_sub;
    logic [1:0]       in_rm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_s;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_rm, in_tag, out_ready,
        input  in_ready, out_valid, out_s, out_tag, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_rm, in_tag, out_ready,
        output in_ready, out_valid, out_s, out_tag, out_flags
    );
endinterface

// File: rtl/fadd_stream_ctrl.sv
// Issue/retire controller around a fixed-latency pipelined FP32 adder.
// Credit-based issue means every in-flight sum always has a FIFO slot waiting.
module fadd_stream_ctrl #(
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic              clk,
    input  logic              clrn,
    fadd_stream_ctrl_if.slave io,
    output logic [31:0]       fa_a,
    output logic [31:0]       fa_b,
    output logic              fa_sub,
    output logic [1:0]        fa_rm,
    output logic              fa_e,
    input  logic [31:0]       fa_s,
    output logic              busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + LATENCY + 2);

    logic [31:0]      fa_a_q, fa_a_d, fa_b_q, fa_b_d;
    logic             fa_sub_q, fa_sub_d;
    logic [1:0]       fa_rm_q, fa_rm_d;
    logic             fa_e_q;

    logic [LATENCY:0] flt_vld_q, flt_vld_d;
    logic [TAG_W-1:0] flt_tag_q [LATENCY+1];
    logic [TAG_W-1:0] flt_tag_d [LATENCY+1];

    logic [31:0]      fifo_s_q     [FIFO_DEPTH];
    logic [31:0]      fifo_s_d     [FIFO_DEPTH];
    logic [TAG_W-1:0] fifo_tag_q   [FIFO_DEPTH];
    logic [TAG_W-1:0] fifo_tag_d   [FIFO_DEPTH];
    logic [3:0]       fifo_flags_q [FIFO_DEPTH];
    logic [3:0]       fifo_flags_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [OCC_W-1:0] occ;
    logic             in_ready;
    logic             accept, push, pop;
    logic [3:0]       push_flags;

    // Occupancy counts every op from issue until its result is popped.
    always_comb begin
        occ = OCC_W'(cnt_q);
        for (int i = 0; i <= LATENCY; i++) begin
            occ = occ + OCC_W'(flt_vld_q[i]);
        end
    end

    assign in_ready = (occ < OCC_W'(FIFO_DEPTH));
    assign busy     = (occ != '0);
    assign accept   = io.in_valid && in_ready;
    assign push     = flt_vld_q[LATENCY];
    assign pop      = (cnt_q != '0) && io.out_ready;

    always_comb begin
        push_flags = 4'b0000;
        if (fa_s[30:23] == 8'hff) begin
            push_flags = (fa_s[22:0] != '0) ? 4'b1000 : 4'b0100;
        end else if (fa_s[30:23] == 8'h00) begin
            push_flags = (fa_s[22:0] != '0) ? 4'b0001 : 4'b0010;
        end
    end

    assign flt_vld_d[0] = accept;
    assign flt_tag_d[0] = io.in_tag;
    for (genvar gi = 1; gi <= LATENCY; gi++) begin : g_shift
        assign flt_vld_d[gi] = flt_vld_q[gi-1];
        assign flt_tag_d[gi] = flt_tag_q[gi-1];
    end

    always_comb begin
        fa_a_d   = fa_a_q;
        fa_b_d   = fa_b_q;
        fa_sub_d = fa_sub_q;
        fa_rm_d  = fa_rm_q;
        if (accept) begin
            fa_a_d   = io.in_a;
            fa_b_d   = io.in_b;
            fa_sub_d = io.in_sub;
            fa_rm_d  = io.in_rm;
        end
    end

    always_comb begin
        fifo_s_d     = fifo_s_q;
        fifo_tag_d   = fifo_tag_q;
        fifo_flags_d = fifo_flags_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        if (push) begin
            fifo_s_d[wr_ptr_q]     = fa_s;
            fifo_tag_d[wr_ptr_q]   = flt_tag_q[LATENCY];
            fifo_flags_d[wr_ptr_q] = push_flags;
            wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fa_a_q    <= '0;
            fa_b_q    <= '0;
            fa_sub_q  <= 1'b0;
            fa_rm_q   <= '0;
            fa_e_q    <= 1'b0;
            flt_vld_q <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                flt_tag_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_s_q[i]     <= '0;
                fifo_tag_q[i]   <= '0;
                fifo_flags_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            fa_a_q       <= fa_a_d;
            fa_b_q       <= fa_b_d;
            fa_sub_q     <= fa_sub_d;
            fa_rm_q      <= fa_rm_d;
            fa_e_q       <= 1'b1;
            flt_vld_q    <= flt_vld_d;
            flt_tag_q    <= flt_tag_d;
            fifo_s_q     <= fifo_s_d;
            fifo_tag_q   <= fifo_tag_d;
            fifo_flags_q <= fifo_flags_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign fa_a         = fa_a_q;
    assign fa_b         = fa_b_q;
    assign fa_sub       = fa_sub_q;
    assign fa_rm        = fa_rm_q;
    assign fa_e         = fa_e_q;
    assign io.in_ready  = in_ready;
    assign io.out_valid = (cnt_q != '0);
    assign io.out_s     = fifo_s_q[rd_ptr_q];
    assign io.out_tag   = fifo_tag_q[rd_ptr_q];
    assign io.out_flags = fifo_flags_q[rd_ptr_q];
endmodule

// File: tb/tb_fadd_stream_ctrl.sv
// Directed bench for fadd_stream_ctrl with a behavioural 2-stage FP32 adder (round-to-nearest-even).
module tb_fadd_stream_ctrl;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int TW    = 4;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    fadd_stream_ctrl_if #(.TAG_W(TW)) io ();

    logic [31:0] fa_a, fa_b, fa_s, st1_q;
    logic        fa_sub, fa_e, busy;
    logic [1:0]  fa_rm;

    fadd_stream_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk(clk), .clrn(clrn), .io(io),
        .fa_a(fa_a), .fa_b(fa_b), .fa_sub(fa_sub), .fa_rm(fa_rm),
        .fa_e(fa_e), .fa_s(fa_s), .busy(busy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int outstanding = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [31:0] fadd_ref(input logic [31:0] a_in, input logic [31:0] b_in,
                                             input logic sub);
        logic [31:0] x, y, t;
        logic        sx, sy, ts, g, st;
        logic [63:0] mx, my, r;
        logic [24:0] man;
        int          ex, ey, d, e;
        x = a_in; y = b_in;
        sx = x[31]; sy = y[31] ^ sub;
        if ((x[30:23] == 8'hff && x[22:0] != 0) || (y[30:23] == 8'hff && y[22:0] != 0))
            return 32'h7fc00000;
        if (x[30:23] == 8'hff) begin
            if (y[30:23] == 8'hff && sx != sy) return 32'h7fc00000;
            return {sx, x[30:0]};
        end
        if (y[30:23] == 8'hff) return {sy, y[30:0]};
        if (y[30:0] > x[30:0]) begin
            t = x; x = y; y = t; ts = sx; sx = sy; sy = ts;
        end
        ex = (x[30:23] == 0) ? 1 : int'(x[30:23]);
        ey = (y[30:23] == 0) ? 1 : int'(y[30:23]);
        mx = {40'b0, x[30:23] != 0, x[22:0]} << 30;
        my = {40'b0, y[30:23] != 0, y[22:0]} << 30;
        d  = ex - ey;
        if (d > 60) my = (my != 0) ? 64'd1 : 64'd0;
        else begin
            st = (my & ((64'd1 << d) - 64'd1)) != 0;
            my = (my >> d) | {63'b0, st};
        end
        r = (sx == sy) ? mx + my : mx - my;
        if (r == 0) return {sx & sy, 31'b0};
        e = ex;
        if (r[54]) begin r = (r >> 1) | {63'b0, r[0]}; e++; end
        while (!r[53] && e > 1) begin r = r << 1; e--; end
        man = {1'b0, r[53:30]};
        g   = r[29];
        st  = |r[28:0];
        if (g && (st || man[0])) man = man + 25'd1;
        if (man[24]) begin man = man >> 1; e++; end
        if (e >= 255) return {sx, 8'hff, 23'b0};
        return {sx, man[23] ? 8'(e) : 8'h00, man[22:0]};
    endfunction

    function automatic logic [3:0] cls(input logic [31:0] s);
        if (s[30:23] == 8'hff) return (s[22:0] != 0) ? 4'b1000 : 4'b0100;
        if (s[30:23] == 8'h00) return (s[22:0] != 0) ? 4'b0001 : 4'b0010;
        return 4'b0000;
    endfunction

    // Behavioural stand-in for pipelined_fadder: LAT register stages, shares clrn.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            st1_q <= '0;
            fa_s  <= '0;
        end else if (fa_e) begin
            st1_q <= fadd_ref(fa_a, fa_b, fa_sub);
            fa_s  <= st1_q;
        end
    end

    // Credit invariant: accepted-but-not-popped ops never exceed the FIFO depth.
    always @(negedge clk) begin
        if (!clrn) outstanding = 0;
        else begin
            if (io.in_valid && io.in_ready) outstanding++;
            if (io.out_valid && io.out_ready) outstanding--;
            if (outstanding > DEPTH) chk("credit_overflow", 64'(outstanding), 64'(DEPTH));
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [1:0] rm, input logic [3:0] tag);
        int n = 0;
        @(posedge clk); #1;
        io.in_valid = 1'b1; io.in_a = a; io.in_b = b;
        io.in_sub = sub; io.in_rm = rm; io.in_tag = tag;
        do begin @(negedge clk); n++; end while (!io.in_ready && n < 50);
        if (!io.in_ready) chk("issue_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [31:0] s, output logic [3:0] tag,
                               output logic [3:0] fl, output int lat);
        lat = 0; s = '0; tag = '0; fl = '0;
        while (lat < 20) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (io.out_valid) begin
                s = io.out_s; tag = io.out_tag; fl = io.out_flags;
                break;
            end
        end
        $display("result tag=%0d s=%08h flags=%04b latency=%0d", tag, s, fl, lat);
    endtask

    logic [31:0] cls_a   [4] = '{32'h7f800000, 32'h7f800000, 32'h00000007, 32'h3f800000};
    logic [31:0] cls_b   [4] = '{32'h7f800000, 32'h7f800000, 32'h00000008, 32'h3f800000};
    logic        cls_sub [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] cls_s   [4] = '{32'h7f800000, 32'h7f800000, 32'h80000001, 32'h00000000};
    logic [31:0] cls_msk [4] = '{32'hffffffff, 32'h7f800000, 32'hffffffff, 32'hffffffff};
    logic [3:0]  cls_fl  [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};

    logic [31:0] st_a [50];
    logic [31:0] st_b [50];
    logic        st_sub [50];
    logic [39:0] exp_q [$];

    logic [31:0] rs;
    logic [3:0]  rtag, rfl;
    int          rlat, acc, stall, ov, drv_cyc;

    initial begin
        io.in_valid = 0; io.in_a = 0; io.in_b = 0; io.in_sub = 0;
        io.in_rm = 0; io.in_tag = 0; io.out_ready = 0;

        // Reset held with random traffic on the inputs.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            io.in_valid = 1; io.in_a = $urandom; io.in_b = $urandom;
            io.in_sub = 1; io.in_rm = 2'b11; io.in_tag = 4'hf; io.out_ready = 1;
        end
        @(negedge clk);
        chk("rst_in_ready", 64'(io.in_ready), 64'd1);
        chk("rst_out_valid", 64'(io.out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fa_e", 64'(fa_e), 64'd0);
        chk("rst_fa_ab", {fa_a, fa_b}, 64'd0);
        chk("rst_fa_ctl", 64'({fa_sub, fa_rm}), 64'd0);
        chk("rst_head", 64'({io.out_s, io.out_tag, io.out_flags}), 64'd0);
        io.in_valid = 0; io.out_ready = 1;
        #2 clrn = 1;
        #1 chk("fa_e_before_edge", 64'(fa_e), 64'd0);
        @(posedge clk); #1 chk("fa_e_first_edge", 64'(fa_e), 64'd1);

        // Single-op latency.
        issue(32'h3c600011, 32'hbe820000, 1'b1, 2'b00, 4'd5);
        chk("issue_fa_ab", {fa_a, fa_b}, {32'h3c600011, 32'hbe820000});
        chk("issue_fa_ctl", 64'({fa_sub, fa_rm}), 64'b100);
        chk("lat_busy", 64'(busy), 64'd1);
        wait_result(rs, rtag, rfl, rlat);
        chk("lat_cycles", 64'(rlat), 64'd3);
        chk("lat_s", 64'(rs), 64'h3e890001);
        chk("lat_tag", 64'(rtag), 64'd5);
        chk("lat_flags", 64'(rfl), 64'd0);
        @(negedge clk);
        chk("lat_one_cycle", 64'(io.out_valid), 64'd0);
        chk("lat_idle_busy", 64'(busy), 64'd0);

        // Result classes.
        for (int i = 0; i < 4; i++) begin
            issue(cls_a[i], cls_b[i], cls_sub[i], 2'b00, 4'(8 + i));
            wait_result(rs, rtag, rfl, rlat);
            chk("cls_s", 64'(rs & cls_msk[i]), 64'(cls_s[i]));
            chk("cls_flags", 64'(rfl), 64'(cls_fl[i]));
            chk("cls_tag", 64'(rtag), 64'(8 + i));
        end
        @(negedge clk);

        // Backpressure: consumer stalled, producer always valid.
        io.out_ready = 0; acc = 0; stall = 0;
        @(posedge clk); #1;
        io.in_valid = 1; io.in_a = 0; io.in_b = 0; io.in_sub = 0; io.in_rm = 0; io.in_tag = 0;
        for (int c = 0; c < 16; c++) begin
            automatic logic took;
            @(negedge clk);
            took = io.in_ready;
            if (took) acc++; else stall++;
            @(posedge clk); #1;
            if (took) io.in_tag = io.in_tag + 4'd1;
        end
        io.in_valid = 0;
        chk("bp_accepts", 64'(acc), 64'd4);
        chk("bp_stall_ge10", 64'(stall >= 10), 64'd1);
        io.out_ready = 1;
        @(negedge clk);
        chk("bp_pop0", 64'({io.out_valid, io.out_tag}), 64'({1'b1, 4'd0}));
        chk("bp_ready_before_pop", 64'(io.in_ready), 64'd0);
        @(negedge clk);
        chk("bp_ready_after_pop", 64'(io.in_ready), 64'd1);
        chk("bp_pop1", 64'({io.out_valid, io.out_tag}), 64'({1'b1, 4'd1}));
        @(negedge clk);
        chk("bp_pop2", 64'({io.out_valid, io.out_tag}), 64'({1'b1, 4'd2}));
        @(negedge clk);
        chk("bp_pop3", 64'({io.out_valid, io.out_tag}), 64'({1'b1, 4'd3}));
        @(negedge clk);
        chk("bp_drained", 64'({io.out_valid, busy}), 64'd0);

        // Full-throughput streaming against the reference adder.
        for (int i = 0; i < 50; i++) begin
            st_a[i]   = $urandom;
            st_b[i]   = (i % 3 == 0) ? (st_a[i] ^ 32'($urandom_range(0, 255))) : $urandom;
            st_sub[i] = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        fork
            begin
                int i = 0;
                logic took;
                drv_cyc = 0;
                io.in_valid = 1; io.in_a = st_a[0]; io.in_b = st_b[0];
                io.in_sub = st_sub[0]; io.in_rm = 0; io.in_tag = 0;
                while (i < 50 && drv_cyc < 1000) begin
                    @(negedge clk);
                    took = io.in_ready;
                    if (took) begin
                        automatic logic [31:0] s = fadd_ref(st_a[i], st_b[i], st_sub[i]);
                        exp_q.push_back({s, 4'(i), cls(s)});
                    end
                    @(posedge clk); #1;
                    drv_cyc++;
                    if (took) begin
                        i++;
                        if (i < 50) begin
                            io.in_a = st_a[i]; io.in_b = st_b[i];
                            io.in_sub = st_sub[i]; io.in_tag = 4'(i);
                        end
                    end
                end
                io.in_valid = 0;
                chk("st_throughput", 64'(drv_cyc <= 100), 64'd1);
            end
            begin
                int got = 0;
                int rc  = 0;
                while (got < 50 && rc < 1200) begin
                    @(negedge clk); rc++;
                    if (io.out_valid) begin
                        $display("stream tag=%0d s=%08h flags=%04b", io.out_tag, io.out_s, io.out_flags);
                        if (exp_q.size() == 0) chk("st_unexpected", 64'd1, 64'd0);
                        else chk("st_result", 64'({io.out_s, io.out_tag, io.out_flags}), 64'(exp_q.pop_front()));
                        got++;
                    end
                end
                chk("st_count", 64'(got), 64'd50);
            end
        join
        @(negedge clk);
        chk("st_idle", 64'({io.out_valid, busy}), 64'd0);

        // Reset while three ops are in flight.
        @(posedge clk); #1;
        io.in_valid = 1; io.in_a = 32'h3f800000; io.in_b = 32'h3f800000;
        io.in_sub = 0; io.in_rm = 0; io.in_tag = 1;
        @(posedge clk); #1 io.in_tag = 2;
        @(posedge clk); #1 io.in_tag = 3;
        @(posedge clk); #1 io.in_valid = 0;
        @(negedge clk);
        clrn = 0;
        #1 chk("mid_rst_async", 64'({busy, io.out_valid, io.in_ready, fa_e}), 64'b0010);
        ov = 0;
        repeat (3) begin @(negedge clk); if (io.out_valid) ov++; end
        @(posedge clk); #1 clrn = 1;
        repeat (6) begin @(negedge clk); if (io.out_valid) ov++; end
        chk("mid_rst_no_output", 64'(ov), 64'd0);
        issue(32'h40400000, 32'h3f800000, 1'b0, 2'b00, 4'd9);
        wait_result(rs, rtag, rfl, rlat);
        chk("post_rst_lat", 64'(rlat), 64'd3);
        chk("post_rst_result", 64'({rs, rtag}), 64'({32'h40800000, 4'd9}));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end
endmodule
